// File: rtl/rx_burst_packetizer_pkg.sv
// Shared types and default sizing for the RX burst packetizer and its host word format.
package rx_burst_packetizer_pkg;

  localparam int NUM_PERIPH    = 8;
  localparam int PERIPH_ADDR_W = 3;
  localparam int DATA_WIDTH    = 28;
  localparam int HOST_WORD_W   = 32;
  localparam int MAX_BURST     = 16;

  typedef struct packed {
    logic [PERIPH_ADDR_W-1:0] addr;
    logic                     last;
    logic [DATA_WIDTH-1:0]    payload;
  } host_word_t;

  typedef enum logic [2:0] {
    SETTLE,
    IDLE,
    LOAD,
    CHECK,
    STREAM,
    RELEASE
  } pkt_state_t;

endpackage

// File: rtl/rx_burst_packetizer_if.sv
// Arbiter grant, peripheral RX FIFO and host TX handshake bundle seen by the packetizer.
interface rx_burst_packetizer_if #(
  parameter int NUM_PERIPH = rx_burst_packetizer_pkg::NUM_PERIPH,
  parameter int DATA_WIDTH = rx_burst_packetizer_pkg::DATA_WIDTH
);
  localparam int AW = $clog2(NUM_PERIPH);
  localparam int TW = AW + 1 + DATA_WIDTH;

  logic [AW-1:0]                    grant;
  logic                             read_periph_data;
  logic [NUM_PERIPH-1:0]            rx_fifo_empty;
  logic [NUM_PERIPH*DATA_WIDTH-1:0] rx_fifo_rdata;
  logic [NUM_PERIPH-1:0]            rx_fifo_rd_en;
  logic [TW-1:0]                    tx_data;
  logic                             tx_valid;
  logic                             tx_ready;

  modport master (
    input  grant, rx_fifo_empty, rx_fifo_rdata, tx_ready,
    output read_periph_data, rx_fifo_rd_en, tx_data, tx_valid
  );

  modport slave (
    output grant, rx_fifo_empty, rx_fifo_rdata, tx_ready,
    input  read_periph_data, rx_fifo_rd_en, tx_data, tx_valid
  );

endinterface

// File: rtl/rx_burst_packetizer_mux.sv
// Combinational selection of one FWFT FIFO head out of the flattened peripheral bus.
module rx_word_mux #(
  parameter int NUM_PERIPH = 8,
  parameter int DATA_WIDTH = 28
) (
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0] i_rdata,
  input  logic [$clog2(NUM_PERIPH)-1:0]    i_sel,
  output logic [DATA_WIDTH-1:0]            o_word
);
  localparam int AW = $clog2(NUM_PERIPH);

  always_comb begin
    o_word = '0;
    for (int unsigned i = 0; i < NUM_PERIPH; i++) begin
      if (i_sel == AW'(i)) o_word = i_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/rx_burst_packetizer.sv
// Drains the granted peripheral RX FIFO in bursts, tags words with {addr,last} and
// pulses read_periph_data when the burst ends so the arbiter can advance.
module rx_burst_packetizer #(
  parameter int NUM_PERIPH = rx_burst_packetizer_pkg::NUM_PERIPH,
  parameter int DATA_WIDTH = rx_burst_packetizer_pkg::DATA_WIDTH,
  parameter int MAX_BURST  = rx_burst_packetizer_pkg::MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  rx_burst_packetizer_if.master bus
);
  import rx_burst_packetizer_pkg::*;

  localparam int              AW      = $clog2(NUM_PERIPH);
  localparam int              CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_BURST);

  pkt_state_t            r_state;
  pkt_state_t            w_next;
  logic [AW-1:0]         r_sel;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_last;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_any_ne;
  logic                  w_grant_ne;
  logic                  w_hs;
  logic                  w_pop;

  rx_word_mux #(
    .NUM_PERIPH(NUM_PERIPH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mux (
    .i_rdata(bus.rx_fifo_rdata),
    .i_sel  (r_sel),
    .o_word (w_head)
  );

  assign w_any_ne   = ~&bus.rx_fifo_empty;
  assign w_grant_ne = ~bus.rx_fifo_empty[bus.grant];
  assign w_hs       = (r_state == STREAM) && bus.tx_ready;
  // A pop on handshake is only issued while more words are known to exist (last=0).
  assign w_pop      = (r_state == LOAD) || (w_hs && !r_last);

  always_ff @(posedge clk) begin
    if (rst) r_state <= SETTLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next               = r_state;
    bus.read_periph_data = 1'b0;
    bus.tx_valid         = 1'b0;
    bus.tx_data          = '0;
    bus.rx_fifo_rd_en    = '0;
    unique case (r_state)
      SETTLE: w_next = IDLE;
      IDLE: begin
        if (w_grant_ne)    w_next = LOAD;
        else if (w_any_ne) w_next = RELEASE;
      end
      LOAD:  w_next = CHECK;
      CHECK: w_next = STREAM;
      STREAM: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = {r_sel, r_last, r_hold};
        if (bus.tx_ready) w_next = r_last ? RELEASE : CHECK;
      end
      RELEASE: begin
        bus.read_periph_data = 1'b1;
        w_next               = SETTLE;
      end
      default: w_next = SETTLE;
    endcase
    if (w_pop) bus.rx_fifo_rd_en[r_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel  <= '0;
      r_hold <= '0;
      r_last <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (r_state == IDLE) r_sel <= bus.grant;
      if (w_pop) begin
        r_hold <= w_head;
        r_cnt  <= (r_state == LOAD) ? CW'(1) : r_cnt + 1'b1;
      end
      // Empty flag is sampled one cycle after the pop, so it reflects the post-pop FIFO.
      if (r_state == CHECK) r_last <= (r_cnt == MAX_CNT) || bus.rx_fifo_empty[r_sel];
    end
  end

endmodule

// File: tb/tb_rx_burst_packetizer.sv
// Randomized bench for rx_burst_packetizer: FIFO/arbiter environment plus a per-peripheral
// word scoreboard that predicts payload order, burst boundaries and release pulses.
module tb_rx_burst_packetizer;
  import rx_burst_packetizer_pkg::*;

  localparam int NP = NUM_PERIPH;
  localparam int DW = DATA_WIDTH;
  localparam int MB = MAX_BURST;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_burst_packetizer_if #(.NUM_PERIPH(NP), .DATA_WIDTH(DW)) bus ();

  rx_burst_packetizer #(
    .NUM_PERIPH(NP),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]            fifo_q [NP][$];
  logic [DW-1:0]            ref_q  [NP][$];
  logic [PERIPH_ADDR_W-1:0] arb_grant = '0;
  logic [NP-1:0]            pend_pop = '0;
  logic [31:0]              stall_data = '0;
  int  pop_cnt [NP];
  int  pulse_cnt = 0;
  int  burst_n = 0;
  int  push_pct = 0;
  int  ready_pct = 100;
  bit  drv_rst = 1'b1;
  bit  drv_ready = 1'b1;
  bit  rand_ready = 1'b0;
  bit  glitch = 1'b0;
  bit  rst_prev = 1'b1;
  bit  pulse_due = 1'b0;
  bit  arb_pending = 1'b0;
  bit  stall_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input int p);
    logic [DW-1:0] w;
    w = DW'($urandom);
    fifo_q[p].push_back(w);
    ref_q[p].push_back(w);
  endtask

  function automatic int total_left();
    int n = 0;
    for (int i = 0; i < NP; i++) n += ref_q[i].size();
    return n;
  endfunction

  // Round-robin arbiter: next non-empty requester after the current grant.
  task automatic arbitrate();
    int idx;
    for (int k = 1; k <= NP; k++) begin
      idx = (int'(arb_grant) + k) % NP;
      if (fifo_q[idx].size() != 0) begin
        arb_grant = PERIPH_ADDR_W'(idx);
        break;
      end
    end
  endtask

  task automatic scoreboard(input host_word_t w);
    logic [DW-1:0] e;
    check_eq("addr", 32'(w.addr), 32'(arb_grant));
    if (ref_q[arb_grant].size() == 0) begin
      check_eq("word_expected", 32'(ref_q[arb_grant].size()), 32'd1);
    end else begin
      e = ref_q[arb_grant].pop_front();
      check_eq("payload", 32'(w.payload), 32'(e));
    end
    burst_n++;
    check_eq("last", 32'(w.last), 32'(burst_n == MB || ref_q[arb_grant].size() == 0));
    if (w.last) begin
      burst_n   = 0;
      pulse_due = 1'b1;
    end
  endtask

  task automatic observe();
    host_word_t w;
    bit any_ne;
    w = bus.tx_data;
    if (rst_prev) begin
      check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check_eq("rst_rd_en", 32'(bus.rx_fifo_rd_en), 32'd0);
      check_eq("rst_pulse", 32'(bus.read_periph_data), 32'd0);
      return;
    end
    check_eq("rd_en_onehot", 32'($countones(bus.rx_fifo_rd_en) <= 1), 32'd1);
    if (bus.rx_fifo_rd_en != '0) begin
      check_eq("rd_en_sel", 32'(bus.rx_fifo_rd_en), 32'd1 << arb_grant);
      check_eq("pop_nonempty", 32'(fifo_q[arb_grant].size() != 0), 32'd1);
    end
    pend_pop = bus.rx_fifo_rd_en;
    if (stall_valid) begin
      check_eq("stall_valid", 32'(bus.tx_valid), 32'd1);
      check_eq("stall_data", 32'(bus.tx_data), stall_data);
    end
    if (bus.tx_valid && !bus.tx_ready) check_eq("stall_no_pop", 32'(bus.rx_fifo_rd_en), 32'd0);
    stall_valid = bus.tx_valid && !bus.tx_ready;
    stall_data  = 32'(bus.tx_data);
    any_ne = 1'b0;
    for (int i = 0; i < NP; i++) if (fifo_q[i].size() != 0) any_ne = 1'b1;
    if (pulse_due) begin
      check_eq("pulse_after_last", 32'(bus.read_periph_data), 32'd1);
      pulse_due = 1'b0;
    end else if (bus.read_periph_data) begin
      check_eq("skip_legal", 32'(burst_n == 0 && fifo_q[arb_grant].size() == 0 && any_ne), 32'd1);
    end
    if (bus.read_periph_data) begin
      pulse_cnt++;
      arb_pending = 1'b1;
    end
    if (bus.tx_valid && bus.tx_ready) scoreboard(w);
  endtask

  // One clock: FIFO/arbiter updates and input drive on negedge, then sample 1ns later.
  task automatic step();
    logic [DW-1:0] tmp;
    int p;
    @(negedge clk);
    rst_prev = rst;
    for (int i = 0; i < NP; i++) begin
      if (pend_pop[i] && fifo_q[i].size() != 0) begin
        tmp = fifo_q[i].pop_front();
        pop_cnt[i]++;
      end
    end
    pend_pop = '0;
    if (arb_pending) begin
      arbitrate();
      arb_pending = 1'b0;
    end
    if (push_pct > 0 && $urandom_range(99) < push_pct) begin
      p = $urandom_range(NP - 1);
      if (p != int'(arb_grant)) push_word(p);
    end
    rst          = drv_rst;
    bus.tx_ready = rand_ready ? ($urandom_range(99) < ready_pct) : drv_ready;
    bus.grant    = glitch ? (arb_grant ^ PERIPH_ADDR_W'(5)) : arb_grant;
    for (int i = 0; i < NP; i++) begin
      bus.rx_fifo_empty[i] = (fifo_q[i].size() == 0);
      bus.rx_fifo_rdata[i*DW +: DW] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : '0;
    end
    #1;
    observe();
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (total_left() == 0) && (burst_n == 0) && !pulse_due && !arb_pending;
    end
    check_eq(tag, 32'(done), 32'd1);
    repeat (4) step();
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      seen = bus.tx_valid;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    int p0;
    int n0;
    int stalled;
    for (int i = 0; i < NP; i++) pop_cnt[i] = 0;
    bus.grant         = '0;
    bus.tx_ready      = 1'b0;
    bus.rx_fifo_empty = '1;
    bus.rx_fifo_rdata = '0;

    // Reset held 5 cycles, then idle with every FIFO empty.
    repeat (5) step();
    drv_rst = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_tx_valid", 32'(bus.tx_valid), 32'd0);
      check_eq("idle_rd_en", 32'(bus.rx_fifo_rd_en), 32'd0);
      check_eq("idle_pulse", 32'(bus.read_periph_data), 32'd0);
    end

    // Short burst: three words from peripheral 2.
    arb_grant = 3'd2;
    p0 = pop_cnt[2];
    n0 = pulse_cnt;
    repeat (3) push_word(2);
    wait_quiet("quiet_t2", 200);
    check_eq("t2_pops", 32'(pop_cnt[2] - p0), 32'd3);
    check_eq("t2_pulses", 32'(pulse_cnt - n0), 32'd1);

    // Burst cap: 20 words split into MAX_BURST and the remainder.
    arb_grant = 3'd5;
    p0 = pop_cnt[5];
    n0 = pulse_cnt;
    repeat (20) push_word(5);
    wait_quiet("quiet_t3", 400);
    check_eq("t3_pops", 32'(pop_cnt[5] - p0), 32'd20);
    check_eq("t3_pulses", 32'(pulse_cnt - n0), 32'd2);

    // Skip: granted FIFO empty while another one has data.
    arb_grant = 3'd0;
    p0 = pop_cnt[0];
    n0 = pulse_cnt;
    push_word(3);
    step();
    step();
    check_eq("skip_within2", 32'(pulse_cnt - n0), 32'd1);
    wait_quiet("quiet_t4", 200);
    check_eq("t4_no_pop0", 32'(pop_cnt[0] - p0), 32'd0);

    // Backpressure mid-burst with the grant input disturbed meanwhile.
    arb_grant = 3'd1;
    p0 = pop_cnt[1];
    repeat (6) push_word(1);
    drv_ready = 1'b1;
    wait_valid("t5_first_valid");
    drv_ready = 1'b0;
    glitch    = 1'b1;
    stalled   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.tx_valid && !bus.tx_ready) stalled++;
    end
    check_eq("t5_stall_cycles", 32'(stalled), 32'd9);
    glitch    = 1'b0;
    drv_ready = 1'b1;
    wait_quiet("quiet_t5", 200);
    check_eq("t5_pops", 32'(pop_cnt[1] - p0), 32'd6);

    // Reset while a word is held in STREAM; that word is lost.
    arb_grant = 3'd4;
    repeat (5) push_word(4);
    drv_ready = 1'b0;
    wait_valid("t6_valid");
    drv_rst = 1'b1;
    step();
    void'(ref_q[4].pop_front());
    burst_n     = 0;
    stall_valid = 1'b0;
    pulse_due   = 1'b0;
    step();
    drv_rst = 1'b0;
    step();
    drv_ready = 1'b1;
    wait_quiet("quiet_t6", 200);

    // Random traffic and random backpressure across all peripherals.
    push_pct   = 20;
    ready_pct  = 70;
    rand_ready = 1'b1;
    repeat (4000) step();
    push_pct   = 0;
    rand_ready = 1'b0;
    drv_ready  = 1'b1;
    wait_quiet("quiet_rand", 8000);
    check_eq("drain_left", 32'(total_left()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
